// File: rtl/game_pkg.sv
// Shared definitions for the jump game: the state bus encoding seen by both
// jump_sequencer and block_controller, plus the playfield geometry constants.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RELOAD = 3'd1,
        ST_READY  = 3'd2,
        ST_CHARGE = 3'd3,
        ST_JUMP   = 3'd4,
        ST_LAND   = 3'd5,
        ST_OVER   = 3'd6
    } game_state_t;

    // Rightmost legal player centre; jump targets clamp here.
    localparam int unsigned X_MAX        = 639;
    // Half-width of a landing block in pixels.
    localparam int unsigned BLOCK_HALF_W = 20;

endpackage

// File: rtl/btn_edge.sv
// Single-cycle rise/fall pulses from an already-synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise,
    output logic o_fall
);

    logic btn_q;
    logic btn_d;

    // Next history value is simply the current level.
    always_comb btn_d = i_btn;

    // Button history register, one cycle behind i_btn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_q <= 1'b0;
        else        btn_q <= btn_d;
    end

    assign o_rise = i_btn & ~btn_q;
    assign o_fall = ~i_btn & btn_q;

endmodule

// File: rtl/jump_sequencer.sv
// Master game FSM: charge power while the button is held, animate the jump,
// judge the landing against the blocks, keep score and supervise block reloads.
module jump_sequencer
    import game_pkg::*;
#(
    parameter int unsigned POWER_STEP     = 1,
    parameter int unsigned POWER_MAX      = 255,
    parameter int unsigned DIST_SCALE     = 2,
    parameter int unsigned JUMP_SPEED     = 4,
    parameter int unsigned HALF_W         = BLOCK_HALF_W,
    parameter int unsigned X_LIMIT        = X_MAX,
    parameter int unsigned RELOAD_TIMEOUT = 1023
) (
    input  logic        clk_machine,
    input  logic        rst_machine,
    input  logic        i_btn,
    input  logic        i_tick,
    input  logic [31:0] i_x_block1,
    input  logic [31:0] i_x_block2,
    input  logic        i_en_block2,
    input  logic        i_reload_done,
    output logic [2:0]  o_state,
    output logic [15:0] o_power,
    output logic [31:0] o_x_player,
    output logic [15:0] o_score,
    output logic        o_game_over
);

    localparam logic [15:0] WD_LIMIT = 16'(RELOAD_TIMEOUT);

    game_state_t state_q, state_d;
    logic [15:0] power_q, power_d;
    logic [31:0] x_q, x_d;
    logic [31:0] target_q, target_d;
    logic [15:0] score_q, score_d;
    logic        game_over_q, game_over_d;
    logic [15:0] wdog_q, wdog_d;

    logic        rise, fall;
    logic [31:0] pwr_inc, reach, x_next;

    btn_edge u_btn_edge (
        .clk    (clk_machine),
        .rst_n  (rst_machine),
        .i_btn  (i_btn),
        .o_rise (rise),
        .o_fall (fall)
    );

    function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Next-state and datapath update for every game state.
    always_comb begin
        state_d  = state_q;
        power_d  = power_q;
        x_d      = x_q;
        target_d = target_q;
        score_d  = score_q;
        wdog_d   = '0;
        pwr_inc  = {16'd0, power_q} + 32'(POWER_STEP);
        reach    = x_q + ({16'd0, power_q} * 32'(DIST_SCALE));
        x_next   = x_q + 32'(JUMP_SPEED);

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    score_d = '0;
                    x_d     = i_x_block1;
                    state_d = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                wdog_d = wdog_q + 16'd1;
                if (i_reload_done) begin
                    x_d     = i_x_block1;
                    wdog_d  = '0;
                    state_d = ST_READY;
                end else if (wdog_d == WD_LIMIT) begin
                    wdog_d  = '0;
                    state_d = ST_OVER;
                end
            end
            ST_READY: begin
                if (rise) begin
                    power_d = '0;
                    state_d = ST_CHARGE;
                end
            end
            ST_CHARGE: begin
                // A release in the same cycle as a tick wins; no increment.
                if (fall) begin
                    target_d = (reach > 32'(X_LIMIT)) ? 32'(X_LIMIT) : reach;
                    state_d  = ST_JUMP;
                end else if (i_tick) begin
                    power_d = (pwr_inc > 32'(POWER_MAX)) ? 16'(POWER_MAX) : pwr_inc[15:0];
                end
            end
            ST_JUMP: begin
                if (i_tick) begin
                    if (x_next >= target_q) begin
                        x_d     = target_q;
                        state_d = ST_LAND;
                    end else begin
                        x_d = x_next;
                    end
                end
            end
            ST_LAND: begin
                // Block2 is judged first so a landing in the overlap scores.
                if (i_en_block2 && (absdiff(x_q, i_x_block2) <= 32'(HALF_W))) begin
                    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                    state_d = ST_RELOAD;
                end else if (absdiff(x_q, i_x_block1) <= 32'(HALF_W)) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    // Game state and registered outputs.
    always_ff @(posedge clk_machine or negedge rst_machine) begin
        if (!rst_machine) begin
            state_q     <= ST_IDLE;
            power_q     <= '0;
            x_q         <= '0;
            target_q    <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            power_q     <= power_d;
            x_q         <= x_d;
            target_q    <= target_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            wdog_q      <= wdog_d;
        end
    end

    assign o_state     = state_q;
    assign o_power     = power_q;
    assign o_x_player  = x_q;
    assign o_score     = score_q;
    assign o_game_over = game_over_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed bench for jump_sequencer: drives on falling edges, samples there too.
module tb_jump_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_btn = 1'b0;
    logic        i_tick = 1'b0;
    logic [31:0] i_x_block1 = 32'd0;
    logic [31:0] i_x_block2 = 32'd0;
    logic        i_en_block2 = 1'b0;
    logic        i_reload_done = 1'b0;
    logic [2:0]  o_state;
    logic [15:0] o_power;
    logic [31:0] o_x_player;
    logic [15:0] o_score;
    logic        o_game_over;

    int total = 0;
    int bad   = 0;

    jump_sequencer dut (
        .clk_machine   (clk),
        .rst_machine   (rst_n),
        .i_btn         (i_btn),
        .i_tick        (i_tick),
        .i_x_block1    (i_x_block1),
        .i_x_block2    (i_x_block2),
        .i_en_block2   (i_en_block2),
        .i_reload_done (i_reload_done),
        .o_state       (o_state),
        .o_power       (o_power),
        .o_x_player    (o_x_player),
        .o_score       (o_score),
        .o_game_over   (o_game_over)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        i_tick = 1'b1;
        repeat (n) @(negedge clk);
        i_tick = 1'b0;
    endtask

    task automatic reload_pulse(input logic [31:0] x1);
        i_x_block1    = x1;
        i_reload_done = 1'b1;
        @(negedge clk);
        i_reload_done = 1'b0;
    endtask

    task automatic test_reset;
        cyc(2);
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        total++; if (o_power !== 16'd0)  begin bad++; $display("FAIL reset_power got=%0d exp=0", o_power); end
        total++; if (o_x_player !== 32'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", o_x_player); end
        total++; if (o_score !== 16'd0)  begin bad++; $display("FAIL reset_score got=%0d exp=0", o_score); end
        total++; if (o_game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%0d exp=0", o_game_over); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_start;
        i_x_block1 = 32'd50;
        i_btn = 1'b1; cyc(1);
        total++; if (o_state !== 3'd1)    begin bad++; $display("FAIL start_state got=%0d exp=1", o_state); end
        total++; if (o_x_player !== 32'd50) begin bad++; $display("FAIL start_x got=%0d exp=50", o_x_player); end
        i_btn = 1'b0; cyc(1);
        total++; if (o_state !== 3'd1)    begin bad++; $display("FAIL reload_ignore_btn got=%0d exp=1", o_state); end
        reload_pulse(32'd100);
        total++; if (o_state !== 3'd2)    begin bad++; $display("FAIL ready_state got=%0d exp=2", o_state); end
        total++; if (o_x_player !== 32'd100) begin bad++; $display("FAIL ready_x got=%0d exp=100", o_x_player); end
    endtask

    task automatic test_charge_land;
        i_btn = 1'b1; cyc(1);
        total++; if (o_state !== 3'd3)  begin bad++; $display("FAIL charge_state got=%0d exp=3", o_state); end
        ticks(10);
        total++; if (o_power !== 16'd10) begin bad++; $display("FAIL charge_power got=%0d exp=10", o_power); end
        i_btn = 1'b0; cyc(1);
        total++; if (o_state !== 3'd4)  begin bad++; $display("FAIL jump_state got=%0d exp=4", o_state); end
        i_x_block2 = 32'd125; i_en_block2 = 1'b1;
        ticks(4);
        total++; if (o_x_player !== 32'd116) begin bad++; $display("FAIL jump_x4 got=%0d exp=116", o_x_player); end
        total++; if (o_state !== 3'd4)  begin bad++; $display("FAIL jump_state4 got=%0d exp=4", o_state); end
        ticks(1);
        total++; if (o_x_player !== 32'd120) begin bad++; $display("FAIL jump_x5 got=%0d exp=120", o_x_player); end
        total++; if (o_state !== 3'd5)  begin bad++; $display("FAIL land_state got=%0d exp=5", o_state); end
        cyc(1);
        total++; if (o_score !== 16'd1) begin bad++; $display("FAIL hit2_score got=%0d exp=1", o_score); end
        total++; if (o_state !== 3'd1)  begin bad++; $display("FAIL hit2_state got=%0d exp=1", o_state); end
        reload_pulse(32'd100);
        total++; if (o_state !== 3'd2)  begin bad++; $display("FAIL reload2_state got=%0d exp=2", o_state); end
    endtask

    task automatic test_saturation;
        i_btn = 1'b1; cyc(1);
        ticks(300);
        total++; if (o_power !== 16'd255) begin bad++; $display("FAIL sat_power got=%0d exp=255", o_power); end
        i_btn = 1'b0; cyc(1);
        i_x_block2 = 32'd300; i_en_block2 = 1'b1;
        ticks(127);
        total++; if (o_x_player !== 32'd608) begin bad++; $display("FAIL sat_x127 got=%0d exp=608", o_x_player); end
        total++; if (o_state !== 3'd4)   begin bad++; $display("FAIL sat_jump got=%0d exp=4", o_state); end
        ticks(1);
        total++; if (o_x_player !== 32'd610) begin bad++; $display("FAIL sat_target got=%0d exp=610", o_x_player); end
        cyc(1);
        total++; if (o_state !== 3'd6)   begin bad++; $display("FAIL miss_state got=%0d exp=6", o_state); end
        total++; if (o_game_over !== 1'b1) begin bad++; $display("FAIL miss_over got=%0d exp=1", o_game_over); end
        cyc(3);
        total++; if (o_score !== 16'd1)  begin bad++; $display("FAIL over_score got=%0d exp=1", o_score); end
        i_btn = 1'b1; cyc(1);
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL over_exit got=%0d exp=0", o_state); end
        total++; if (o_game_over !== 1'b0) begin bad++; $display("FAIL idle_over got=%0d exp=0", o_game_over); end
    endtask

    task automatic test_block1;
        i_btn = 1'b0; cyc(1);
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL idle_fall got=%0d exp=0", o_state); end
        i_x_block1 = 32'd100;
        i_btn = 1'b1; cyc(1);
        total++; if (o_score !== 16'd0)  begin bad++; $display("FAIL restart_score got=%0d exp=0", o_score); end
        i_btn = 1'b0;
        reload_pulse(32'd100);
        i_btn = 1'b1; cyc(1);
        ticks(5);
        i_btn = 1'b0; cyc(1);
        total++; if (o_power !== 16'd5)  begin bad++; $display("FAIL b1_power got=%0d exp=5", o_power); end
        i_x_block2 = 32'd200; i_en_block2 = 1'b1;
        ticks(3);
        total++; if (o_x_player !== 32'd110) begin bad++; $display("FAIL b1_x got=%0d exp=110", o_x_player); end
        cyc(1);
        total++; if (o_state !== 3'd2)   begin bad++; $display("FAIL b1_state got=%0d exp=2", o_state); end
        total++; if (o_score !== 16'd0)  begin bad++; $display("FAIL b1_score got=%0d exp=0", o_score); end
        // Block2 disabled though it would match; block1 exactly HALF_W away.
        i_x_block2 = 32'd110; i_en_block2 = 1'b0;
        i_btn = 1'b1; cyc(1);
        ticks(5);
        i_btn = 1'b0; cyc(1);
        ticks(3);
        total++; if (o_x_player !== 32'd120) begin bad++; $display("FAIL b1en_x got=%0d exp=120", o_x_player); end
        cyc(1);
        total++; if (o_state !== 3'd2)   begin bad++; $display("FAIL b1en_state got=%0d exp=2", o_state); end
        total++; if (o_score !== 16'd0)  begin bad++; $display("FAIL b1en_score got=%0d exp=0", o_score); end
        // Zero power, block1 one pixel beyond HALF_W.
        i_x_block1 = 32'd99;
        i_btn = 1'b1; cyc(1);
        total++; if (o_power !== 16'd0)  begin bad++; $display("FAIL p0_power got=%0d exp=0", o_power); end
        i_btn = 1'b0; cyc(1);
        ticks(1);
        total++; if (o_state !== 3'd5)   begin bad++; $display("FAIL p0_land got=%0d exp=5", o_state); end
        total++; if (o_x_player !== 32'd120) begin bad++; $display("FAIL p0_x got=%0d exp=120", o_x_player); end
        cyc(1);
        total++; if (o_state !== 3'd6)   begin bad++; $display("FAIL p0_miss got=%0d exp=6", o_state); end
        i_btn = 1'b1; cyc(1);
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL p0_idle got=%0d exp=0", o_state); end
    endtask

    task automatic test_timeout;
        i_btn = 1'b0; cyc(1);
        i_btn = 1'b1; cyc(1);
        total++; if (o_state !== 3'd1)   begin bad++; $display("FAIL to_enter got=%0d exp=1", o_state); end
        cyc(1022);
        total++; if (o_state !== 3'd1)   begin bad++; $display("FAIL to_early got=%0d exp=1", o_state); end
        cyc(1);
        total++; if (o_state !== 3'd6)   begin bad++; $display("FAIL to_over got=%0d exp=6", o_state); end
        total++; if (o_game_over !== 1'b1) begin bad++; $display("FAIL to_flag got=%0d exp=1", o_game_over); end
        i_btn = 1'b0; cyc(1);
        i_btn = 1'b1; cyc(1);
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL to_idle got=%0d exp=0", o_state); end
    endtask

    task automatic test_fall_tick;
        i_btn = 1'b0; cyc(1);
        i_btn = 1'b1; cyc(1);
        i_btn = 1'b0;
        reload_pulse(32'd100);
        i_btn = 1'b1; cyc(1);
        ticks(3);
        total++; if (o_power !== 16'd3)  begin bad++; $display("FAIL ft_power3 got=%0d exp=3", o_power); end
        i_btn = 1'b0; i_tick = 1'b1; cyc(1); i_tick = 1'b0;
        total++; if (o_power !== 16'd3)  begin bad++; $display("FAIL ft_noinc got=%0d exp=3", o_power); end
        total++; if (o_state !== 3'd4)   begin bad++; $display("FAIL ft_jump got=%0d exp=4", o_state); end
        i_x_block2 = 32'd106; i_en_block2 = 1'b1;
        ticks(1);
        total++; if (o_x_player !== 32'd104) begin bad++; $display("FAIL ft_x1 got=%0d exp=104", o_x_player); end
        ticks(1);
        total++; if (o_x_player !== 32'd106) begin bad++; $display("FAIL ft_x2 got=%0d exp=106", o_x_player); end
        cyc(1);
        total++; if (o_score !== 16'd1)  begin bad++; $display("FAIL ft_score got=%0d exp=1", o_score); end
    endtask

    task automatic test_reset_mid_jump;
        reload_pulse(32'd100);
        i_btn = 1'b1; cyc(1);
        ticks(4);
        i_btn = 1'b0; cyc(1);
        ticks(1);
        total++; if (o_state !== 3'd4)   begin bad++; $display("FAIL mj_pre_state got=%0d exp=4", o_state); end
        total++; if (o_x_player !== 32'd104) begin bad++; $display("FAIL mj_pre_x got=%0d exp=104", o_x_player); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL mj_state got=%0d exp=0", o_state); end
        total++; if (o_x_player !== 32'd0) begin bad++; $display("FAIL mj_x got=%0d exp=0", o_x_player); end
        total++; if (o_score !== 16'd0)  begin bad++; $display("FAIL mj_score got=%0d exp=0", o_score); end
        total++; if (o_power !== 16'd0)  begin bad++; $display("FAIL mj_power got=%0d exp=0", o_power); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        total++; if (o_state !== 3'd0)   begin bad++; $display("FAIL mj_hold got=%0d exp=0", o_state); end
    endtask

    initial begin
        test_reset;
        test_start;
        test_charge_land;
        test_saturation;
        test_block1;
        test_timeout;
        test_fall_tick;
        test_reset_mid_jump;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jump_sequencer.md
Name: jump_sequencer

Overview:
- Master game FSM for the jump game.
- Drives the 3-bit state bus consumed by block_controller.
- Converts button hold time into jump power and animates the player x-position.
- Judges landing against block positions, keeps score, and handshakes block reloads via reload_done.

Parameters:
- POWER_STEP, 1, power increment per i_tick while charging
- POWER_MAX, 255, saturation limit of charge power
- DIST_SCALE, 2, pixels of jump distance per unit of power
- JUMP_SPEED, 4, player x advance per i_tick during a jump
- HALF_W, 20, half-width of a landing block in pixels
- X_MAX, 639, maximum legal player x; jump targets clamp here
- RELOAD_TIMEOUT, 1023, clk_machine cycles allowed for reload_done before game over

Ports:
- clk_machine  in  1  system clock
- rst_machine  in  1  asynchronous, active-low reset
- i_btn  in  1  debounced, synchronised jump button level; 1 = pressed
- i_tick  in  1  one-cycle game-tick strobe
- i_x_block1  in  32  centre x of the current block
- i_x_block2  in  32  centre x of the next block
- i_en_block2  in  1  next block valid
- i_reload_done  in  1  block_controller finished repositioning blocks; one-cycle pulse
- o_state  out  3  game state bus to block_controller
- o_power  out  16  current charge power
- o_x_player  out  32  player centre x
- o_score  out  16  successful landings on block2
- o_game_over  out  1  high while in OVER

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE, o_power = 0, o_x_player = 0, o_score = 0, o_game_over = 0, reload watchdog = 0, button history register = 0.
- Button edges: rise = i_btn & ~btn_q; fall = ~i_btn & btn_q. btn_q is registered every cycle.
- State encodings: IDLE = 0, RELOAD = 1, READY = 2, CHARGE = 3, JUMP = 4, LAND = 5, OVER = 6. Code 7 is unused; if reached, next state = IDLE.
- IDLE: on rise, clear o_score, set o_x_player = i_x_block1, go to RELOAD.
- RELOAD:
  - Watchdog counts clk_machine cycles.
  - On i_reload_done: o_x_player = i_x_block1 sampled that same cycle, watchdog cleared, go to READY.
  - Watchdog reaching RELOAD_TIMEOUT: go to OVER.
  - i_reload_done takes priority if both occur in the same cycle.
- READY: on rise, o_power = 0, go to CHARGE.
- CHARGE:
  - On i_tick: o_power = min(o_power + POWER_STEP, POWER_MAX).
  - On fall: latch target = min(o_x_player + o_power*DIST_SCALE, X_MAX), go to JUMP.
  - Computation is 32-bit unsigned.
  - If fall and i_tick occur in the same cycle, the fall wins and no increment is applied.
- JUMP:
  - On i_tick: o_x_player += JUMP_SPEED.
  - If the result is >= target, o_x_player = target and go to LAND on the next cycle.
  - Power 0 gives target = o_x_player, so the FSM goes to LAND on the first tick.
- LAND (exactly 1 cycle):
  - Hit on block2: i_en_block2 and |o_x_player - i_x_block2| <= HALF_W. Score increments (saturates at 16'hFFFF), go to RELOAD.
  - Otherwise, hit on block1: |o_x_player - i_x_block1| <= HALF_W. Go to READY, no score change.
  - Block2 is checked first.
  - Otherwise (miss): go to OVER.
- OVER:
  - o_game_over = 1.
  - o_score holds its value.
  - On rise, go to IDLE. o_game_over is cleared on IDLE entry.
- Input handling by state:
  - i_btn edges are ignored in RELOAD, JUMP and LAND.
  - i_tick is ignored outside CHARGE and JUMP.
- o_state is registered and changes on the clock edge that enters the state; there is no combinational path from inputs to outputs.
- Reset asserted in any state aborts immediately to the reset values.

Decomposition:
- Shared package (game_pkg):
  - The 3-bit state encodings, shared with block_controller.
  - X_MAX.
  - The block half-width constant.
- Sub-module: btn_edge, producing the rise/fall pulses from i_btn.
- The absolute-difference compare stays inline, written as a function.

Test Plan:
- Reset mid-JUMP: o_state = 0, o_x_player = 0, o_score = 0, all asynchronously.
- Start: rise in IDLE → o_state = 1. i_reload_done with i_x_block1 = 100 → o_state = 2 and o_x_player = 100.
- Hold for 10 ticks, then release (POWER_STEP = 1, DIST_SCALE = 2): o_power = 10, target 120. The player steps 104…120 over 5 ticks, LAND. With i_x_block2 = 125 and i_en_block2 = 1: o_score = 1, o_state = 1.
- Hold for 300 ticks: o_power saturates at 255, target = min(100 + 510, 639) = 610. Blocks at 100 and 300 → miss → o_state = 6, o_game_over = 1. Then rise → o_state = 0.
- Short hold giving target 110 with i_x_block1 = 100, i_x_block2 = 200: block1 hit → o_state = 2, score unchanged. Repeat with i_en_block2 = 0 and i_x_block2 = 110: still block1, no score.
- RELOAD with no i_reload_done for 1023 cycles → o_state = 6. Separately: fall and i_tick in the same cycle → o_power is not incremented.
